// File: rtl/sdram_arbiter_if.sv
// rtl/sdram_arbiter_if.sv - SDRAM controller command/status bus between arbiter (master) and controller (slave)
interface sdram_arbiter_if;
    logic        sdrc_init_done;
    logic        sdrc_busy_n;
    logic        sdrc_rd_valid;
    logic        sdrc_wrd_ack;
    logic [31:0] sdrc_rd_data;
    logic        sdrc_rd_n;
    logic        sdrc_wr_n;
    logic [20:0] sdrc_addr;
    logic [6:0]  sdrc_data_len;
    logic [3:0]  sdrc_dqm;
    logic [31:0] sdrc_wr_data;
    logic        sdrc_selfrefresh;
    logic        sdrc_power_down;

    modport master (
        input  sdrc_init_done, sdrc_busy_n, sdrc_rd_valid, sdrc_wrd_ack, sdrc_rd_data,
        output sdrc_rd_n, sdrc_wr_n, sdrc_addr, sdrc_data_len, sdrc_dqm, sdrc_wr_data,
               sdrc_selfrefresh, sdrc_power_down
    );

    modport slave (
        output sdrc_init_done, sdrc_busy_n, sdrc_rd_valid, sdrc_wrd_ack, sdrc_rd_data,
        input  sdrc_rd_n, sdrc_wr_n, sdrc_addr, sdrc_data_len, sdrc_dqm, sdrc_wr_data,
               sdrc_selfrefresh, sdrc_power_down
    );
endinterface

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - two-port SDRAM burst arbiter/sequencer; optional watchdog under SDRAM_ARB_TIMEOUT_EN
module sdram_arbiter #(
    parameter int unsigned MAX_P0_BURSTS  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            p0_req,
    input  logic [20:0]     p0_addr,
    input  logic [6:0]      p0_len,
    output logic            p0_ack,
    output logic [31:0]     p0_rd_data,
    output logic            p0_rd_valid,
    output logic            p0_done,
    input  logic            p1_req,
    input  logic            p1_we,
    input  logic [20:0]     p1_addr,
    input  logic [6:0]      p1_len,
    input  logic [3:0]      p1_dqm,
    output logic            p1_ack,
    input  logic [31:0]     p1_wr_data,
    output logic            p1_wr_ready,
    output logic [31:0]     p1_rd_data,
    output logic            p1_rd_valid,
    output logic            p1_done,
    sdram_arbiter_if.master sdrc,
    output logic            timeout_err
);

    localparam int unsigned SW = $clog2(MAX_P0_BURSTS + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_P0_BURSTS);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_ISSUE,
        ST_XFER,
        ST_DONE
    } state_t;

    state_t        state;
    logic          owner;      // 0 = video port, 1 = processor port
    logic          we_q;
    logic [7:0]    beat_cnt;   // 8 bits so a 128-word burst does not wrap
    logic [SW-1:0] starve;

    logic p1_wins;
    logic rd_beat;
    logic wr_beat;

    // Port 1 takes the bus when port 0 is idle or has hogged it long enough
    assign p1_wins = p1_req && (!p0_req || (starve == STARVE_MAX));

    // Only beats seen in XFER for the active direction count or get forwarded
    assign rd_beat = (state == ST_XFER) && !we_q && sdrc.sdrc_rd_valid && (beat_cnt != 8'd0);
    assign wr_beat = (state == ST_XFER) &&  we_q && sdrc.sdrc_wrd_ack  && (beat_cnt != 8'd0);

    // Write data flows straight through; the strobe tells port 1 to advance
    assign sdrc.sdrc_wr_data     = p1_wr_data;
    assign p1_wr_ready           = sdrc.sdrc_wrd_ack && (state == ST_XFER) && owner && we_q;
    assign sdrc.sdrc_selfrefresh = 1'b0;
    assign sdrc.sdrc_power_down  = 1'b0;

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
    logic [WW-1:0] wd_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    // Arbitration, command sequencing, beat counting and read-data routing
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state              <= ST_INIT;
            owner              <= 1'b0;
            we_q               <= 1'b0;
            beat_cnt           <= 8'd0;
            starve             <= '0;
            p0_ack             <= 1'b0;
            p1_ack             <= 1'b0;
            p0_done            <= 1'b0;
            p1_done            <= 1'b0;
            p0_rd_valid        <= 1'b0;
            p1_rd_valid        <= 1'b0;
            p0_rd_data         <= 32'd0;
            p1_rd_data         <= 32'd0;
            sdrc.sdrc_rd_n     <= 1'b1;
            sdrc.sdrc_wr_n     <= 1'b1;
            sdrc.sdrc_addr     <= 21'd0;
            sdrc.sdrc_data_len <= 7'd0;
            sdrc.sdrc_dqm      <= 4'd0;
`ifdef SDRAM_ARB_TIMEOUT_EN
            wd_cnt             <= '0;
            timeout_err        <= 1'b0;
`endif
        end else begin
            p0_ack         <= 1'b0;
            p1_ack         <= 1'b0;
            p0_done        <= 1'b0;
            p1_done        <= 1'b0;
            sdrc.sdrc_rd_n <= 1'b1;
            sdrc.sdrc_wr_n <= 1'b1;
            p0_rd_valid    <= rd_beat && !owner;
            p1_rd_valid    <= rd_beat &&  owner;
            if (rd_beat && !owner) begin
                p0_rd_data <= sdrc.sdrc_rd_data;
            end
            if (rd_beat && owner) begin
                p1_rd_data <= sdrc.sdrc_rd_data;
            end
            if (!p1_req) begin
                starve <= '0;
            end

            case (state)
                ST_INIT: begin
                    if (sdrc.sdrc_init_done) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (sdrc.sdrc_busy_n && (p0_req || p1_req)) begin
                        state <= ST_ISSUE;
                        owner <= p1_wins;
                        if (p1_wins) begin
                            we_q               <= p1_we;
                            sdrc.sdrc_addr     <= p1_addr;
                            sdrc.sdrc_data_len <= p1_len;
                            sdrc.sdrc_dqm      <= p1_dqm;
                            p1_ack             <= 1'b1;
                            starve             <= '0;
                            if (p1_we) begin
                                sdrc.sdrc_wr_n <= 1'b0;
                            end else begin
                                sdrc.sdrc_rd_n <= 1'b0;
                            end
                        end else begin
                            we_q               <= 1'b0;
                            sdrc.sdrc_addr     <= p0_addr;
                            sdrc.sdrc_data_len <= p0_len;
                            sdrc.sdrc_dqm      <= 4'd0;
                            p0_ack             <= 1'b1;
                            sdrc.sdrc_rd_n     <= 1'b0;
                            if (p1_req && (starve != STARVE_MAX)) begin
                                starve <= starve + 1'b1;
                            end
                        end
                    end
                end
                ST_ISSUE: begin
                    beat_cnt <= {1'b0, sdrc.sdrc_data_len} + 8'd1;
                    state    <= ST_XFER;
`ifdef SDRAM_ARB_TIMEOUT_EN
                    wd_cnt   <= '0;
`endif
                end
                ST_XFER: begin
                    if (rd_beat || wr_beat) begin
                        beat_cnt <= beat_cnt - 8'd1;
                    end
                    if (beat_cnt == 8'd0) begin
                        state   <= ST_DONE;
                        p0_done <= !owner;
                        p1_done <= owner;
                    end
`ifdef SDRAM_ARB_TIMEOUT_EN
                    else if (rd_beat || wr_beat) begin
                        wd_cnt <= '0;
                    end else if (wd_cnt == WD_LAST) begin
                        state       <= ST_DONE;
                        p0_done     <= !owner;
                        p1_done     <= owner;
                        timeout_err <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - directed self-checking bench for sdram_arbiter
module tb_sdram_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        p0_req;
    logic [20:0] p0_addr;
    logic [6:0]  p0_len;
    logic        p0_ack;
    logic [31:0] p0_rd_data;
    logic        p0_rd_valid;
    logic        p0_done;
    logic        p1_req;
    logic        p1_we;
    logic [20:0] p1_addr;
    logic [6:0]  p1_len;
    logic [3:0]  p1_dqm;
    logic        p1_ack;
    logic [31:0] p1_wr_data;
    logic        p1_wr_ready;
    logic [31:0] p1_rd_data;
    logic        p1_rd_valid;
    logic        p1_done;
    logic        timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    sdram_arbiter_if sdrc_bus ();

    sdram_arbiter #(
        .MAX_P0_BURSTS  (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .p0_req      (p0_req),
        .p0_addr     (p0_addr),
        .p0_len      (p0_len),
        .p0_ack      (p0_ack),
        .p0_rd_data  (p0_rd_data),
        .p0_rd_valid (p0_rd_valid),
        .p0_done     (p0_done),
        .p1_req      (p1_req),
        .p1_we       (p1_we),
        .p1_addr     (p1_addr),
        .p1_len      (p1_len),
        .p1_dqm      (p1_dqm),
        .p1_ack      (p1_ack),
        .p1_wr_data  (p1_wr_data),
        .p1_wr_ready (p1_wr_ready),
        .p1_rd_data  (p1_rd_data),
        .p1_rd_valid (p1_rd_valid),
        .p1_done     (p1_done),
        .sdrc        (sdrc_bus.master),
        .timeout_err (timeout_err)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int bad;
        int cnt;
        int seen;
        int grant;
        logic [9:0] exp_grant;

        reset_n    = 1'b0;
        p0_req     = 1'b0;
        p0_addr    = 21'd0;
        p0_len     = 7'd0;
        p1_req     = 1'b0;
        p1_we      = 1'b0;
        p1_addr    = 21'd0;
        p1_len     = 7'd0;
        p1_dqm     = 4'd0;
        p1_wr_data = 32'd0;
        sdrc_bus.sdrc_init_done = 1'b0;
        sdrc_bus.sdrc_busy_n    = 1'b1;
        sdrc_bus.sdrc_rd_valid  = 1'b0;
        sdrc_bus.sdrc_wrd_ack   = 1'b0;
        sdrc_bus.sdrc_rd_data   = 32'd0;
        repeat (3) step();

        // reset values
        check("rst_rd_n", sdrc_bus.sdrc_rd_n, 1);
        check("rst_wr_n", sdrc_bus.sdrc_wr_n, 1);
        check("rst_addr", sdrc_bus.sdrc_addr, 0);
        check("rst_dqm", sdrc_bus.sdrc_dqm, 0);
        check("rst_p0_ack", p0_ack, 0);
        check("rst_p1_rd_valid", p1_rd_valid, 0);
        check("rst_p0_rd_data", p0_rd_data, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("selfrefresh", sdrc_bus.sdrc_selfrefresh, 0);

        // init hold: request pending, controller not initialised
        reset_n = 1'b1;
        p0_req  = 1'b1;
        p0_addr = 21'h00100;
        p0_len  = 7'd3;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (p0_ack !== 1'b0 || sdrc_bus.sdrc_rd_n !== 1'b1) bad++;
        end
        check("init_hold_no_grant", bad, 0);
        sdrc_bus.sdrc_init_done = 1'b1;
        step();
        check("init_1cyc_no_ack", p0_ack, 0);
        step();
        check("init_p0_ack", p0_ack, 1);
        check("init_rd_n", sdrc_bus.sdrc_rd_n, 0);
        check("p0_addr_out", sdrc_bus.sdrc_addr, 21'h00100);
        check("p0_len_out", sdrc_bus.sdrc_data_len, 3);
        check("p0_dqm_out", sdrc_bus.sdrc_dqm, 0);
        p0_req = 1'b0;
        step();
        check("issue_one_cycle", sdrc_bus.sdrc_rd_n, 1);
        check("ack_one_cycle", p0_ack, 0);

        // port-0 read of four beats
        for (int i = 0; i < 4; i++) begin
            sdrc_bus.sdrc_rd_valid = 1'b1;
            sdrc_bus.sdrc_rd_data  = 32'hA0 + i;
            step();
            check("p0_rd_valid", p0_rd_valid, 1);
            check("p0_rd_data", p0_rd_data, 32'hA0 + i);
            check("p0_done_early", p0_done, 0);
        end
        sdrc_bus.sdrc_rd_valid = 1'b0;
        step();
        check("p0_done", p0_done, 1);
        check("p0_rd_valid_end", p0_rd_valid, 0);
        step();
        check("p0_done_pulse", p0_done, 0);

        // stray beat in IDLE is dropped
        sdrc_bus.sdrc_rd_valid = 1'b1;
        sdrc_bus.sdrc_rd_data  = 32'hDEAD;
        step();
        sdrc_bus.sdrc_rd_valid = 1'b0;
        step();
        check("stray_p0_valid", p0_rd_valid, 0);
        check("stray_p1_valid", p1_rd_valid, 0);
        check("stray_p0_data", p0_rd_data, 32'hA3);

        // busy controller holds off a port-1 write
        sdrc_bus.sdrc_busy_n = 1'b0;
        p1_req  = 1'b1;
        p1_we   = 1'b1;
        p1_addr = 21'h1ABCD;
        p1_len  = 7'd1;
        p1_dqm  = 4'h3;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (p1_ack !== 1'b0 || sdrc_bus.sdrc_wr_n !== 1'b1) bad++;
        end
        check("busy_no_grant", bad, 0);
        sdrc_bus.sdrc_busy_n = 1'b1;
        step();
        check("p1_ack", p1_ack, 1);
        check("p1_wr_n", sdrc_bus.sdrc_wr_n, 0);
        check("p1_rd_n_high", sdrc_bus.sdrc_rd_n, 1);
        check("p1_dqm_out", sdrc_bus.sdrc_dqm, 4'h3);
        check("p1_addr_out", sdrc_bus.sdrc_addr, 21'h1ABCD);
        check("p1_len_out", sdrc_bus.sdrc_data_len, 1);
        p1_req     = 1'b0;
        p1_wr_data = 32'h11111111;
        #1;
        check("wr_data_pass0", sdrc_bus.sdrc_wr_data, 32'h11111111);
        step();
        check("wr_n_one_cycle", sdrc_bus.sdrc_wr_n, 1);
        sdrc_bus.sdrc_wrd_ack = 1'b1;
        #1;
        check("wr_ready_beat0", p1_wr_ready, 1);
        step();
        p1_wr_data = 32'h22222222;
        #1;
        check("wr_data_pass1", sdrc_bus.sdrc_wr_data, 32'h22222222);
        check("wr_ready_beat1", p1_wr_ready, 1);
        step();
        sdrc_bus.sdrc_wrd_ack = 1'b0;
        #1;
        check("wr_ready_off", p1_wr_ready, 0);
        step();
        check("p1_done", p1_done, 1);
        check("p0_done_not_owner", p0_done, 0);
        step();
        check("p1_done_pulse", p1_done, 0);

        // starvation: both ports request continuously, single-word reads
        p0_req = 1'b1;
        p0_len = 7'd0;
        p1_req = 1'b1;
        p1_we  = 1'b0;
        p1_len = 7'd0;
        exp_grant = 10'b1000010000;
        for (int k = 0; k < 10; k++) begin
            step();
            grant = (p1_ack === 1'b1) ? 1 : ((p0_ack === 1'b1) ? 0 : 2);
            check($sformatf("grant_%0d", k), grant, exp_grant[k]);
            step();
            sdrc_bus.sdrc_rd_valid = 1'b1;
            sdrc_bus.sdrc_rd_data  = 32'hB0 + k;
            step();
            sdrc_bus.sdrc_rd_valid = 1'b0;
            check($sformatf("route_p1_%0d", k), p1_rd_valid, exp_grant[k]);
            check($sformatf("route_p0_%0d", k), p0_rd_valid, !exp_grant[k]);
            step();
            step();
        end
        check("p1_rd_data_last", p1_rd_data, 32'hB9);
        check("p0_rd_data_last", p0_rd_data, 32'hB8);
        p0_req = 1'b0;
        p1_req = 1'b0;
        step();

        // longest burst: 128 words
        p0_req  = 1'b1;
        p0_len  = 7'd127;
        p0_addr = 21'h1FFFFF;
        step();
        check("max_len_ack", p0_ack, 1);
        check("max_len_out", sdrc_bus.sdrc_data_len, 127);
        check("max_addr_out", sdrc_bus.sdrc_addr, 21'h1FFFFF);
        p0_req = 1'b0;
        step();
        sdrc_bus.sdrc_rd_valid = 1'b1;
        cnt = 0;
        bad = 0;
        for (int i = 0; i < 128; i++) begin
            step();
            if (p0_rd_valid === 1'b1) cnt++;
            if (p0_done !== 1'b0) bad++;
        end
        sdrc_bus.sdrc_rd_valid = 1'b0;
        check("max_len_beats", cnt, 128);
        check("max_len_no_early_done", bad, 0);
        step();
        check("max_len_done", p0_done, 1);
        step();

        // reset in the middle of a command aborts to INIT
        p1_req = 1'b1;
        p1_we  = 1'b1;
        p1_len = 7'd3;
        step();
        check("abort_wr_n", sdrc_bus.sdrc_wr_n, 0);
        reset_n = 1'b0;
        p1_req  = 1'b0;
        p0_req  = 1'b1;
        p0_len  = 7'd3;
        p0_addr = 21'h00200;
        step();
        check("abort_wr_n_high", sdrc_bus.sdrc_wr_n, 1);
        check("abort_p1_ack", p1_ack, 0);
        reset_n = 1'b1;
        step();
        check("reinit_no_ack", p0_ack, 0);
        sdrc_bus.sdrc_init_done = 1'b0;
        step();
        check("init_drop_ignored", p0_ack, 1);
        p0_req = 1'b0;
        step();
        for (int i = 0; i < 2; i++) begin
            sdrc_bus.sdrc_rd_valid = 1'b1;
            step();
        end
        sdrc_bus.sdrc_rd_valid = 1'b0;

`ifdef SDRAM_ARB_TIMEOUT_EN
        seen = 0;
        cnt  = 0;
        for (int i = 0; i < 40; i++) begin
            if (seen == 0) begin
                step();
                cnt++;
                if (p0_done === 1'b1) seen = 1;
            end
        end
        check("timeout_done_seen", seen, 1);
        check("timeout_delay_ok", (cnt >= 14 && cnt <= 18) ? 1 : 0, 1);
        check("timeout_err_set", timeout_err, 1);
`else
        for (int i = 0; i < 2; i++) begin
            sdrc_bus.sdrc_rd_valid = 1'b1;
            step();
        end
        sdrc_bus.sdrc_rd_valid = 1'b0;
        step();
        check("recover_done", p0_done, 1);
        check("timeout_err_tied", timeout_err, 0);
`endif
        step();
        p0_req = 1'b1;
        p0_len = 7'd0;
        step();
        check("next_grant", p0_ack, 1);
`ifdef SDRAM_ARB_TIMEOUT_EN
        check("timeout_err_sticky", timeout_err, 1);
`else
        check("timeout_err_still0", timeout_err, 0);
`endif
        p0_req = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-port request arbiter and sequencer in front of the SDRAM controller IP. It shares the single SDRAM command interface between the video line-fetch engine (port 0, read-only, high priority) and the processor/SPI command path (port 1, read/write). It issues one burst at a time, counts data beats, and routes read data and write-data strobes to the owning port. It sits in the `clock` domain between the video/processor logic and the SDRAM controller `I_sdrc_*`/`O_sdrc_*` pins.

## Interface
Parameters:
- `MAX_P0_BURSTS`, 4: consecutive port-0 grants allowed while `p1_req` is pending before port 1 is forced.
- `TIMEOUT_CYCLES`, 1024: per-burst watchdog limit. Used only with `SDRAM_ARB_TIMEOUT_EN`.

Ports:
- `clock` in 1: system clock, same as the SDRAM controller `I_sdrc_clk`.
- `reset_n` in 1: synchronous, active-low reset.
- `p0_req` in 1, `p0_addr` in 21, `p0_len` in 7: port-0 read request. Length is words−1.
- `p0_ack` out 1: grant pulse.
- `p0_rd_data` out 32, `p0_rd_valid` out 1: port-0 read data.
- `p0_done` out 1: end-of-burst pulse for port 0.
- `p1_req` in 1, `p1_we` in 1, `p1_addr` in 21, `p1_len` in 7, `p1_dqm` in 4: port-1 request.
- `p1_ack` out 1: grant pulse.
- `p1_wr_data` in 32, `p1_wr_ready` out 1: write data and its strobe. The port advances to the next word when `p1_wr_ready`=1.
- `p1_rd_data` out 32, `p1_rd_valid` out 1, `p1_done` out 1: port-1 read data and end-of-burst pulse.
- `sdrc_init_done` in 1, `sdrc_busy_n` in 1, `sdrc_rd_valid` in 1, `sdrc_wrd_ack` in 1, `sdrc_rd_data` in 32: status and data from the controller.
- `sdrc_rd_n` out 1, `sdrc_wr_n` out 1, `sdrc_addr` out 21, `sdrc_data_len` out 7, `sdrc_dqm` out 4, `sdrc_wr_data` out 32: commands and data to the controller.
- `sdrc_selfrefresh` out 1, `sdrc_power_down` out 1: constant 0.
- `timeout_err` out 1: sticky watchdog flag.

## Operation
- FSM states: INIT, IDLE, ISSUE, XFER, DONE.
- INIT: waits for `sdrc_init_done`=1, then goes to IDLE.
- IDLE: when `sdrc_busy_n`=1 and any request is present, arbitrate, latch the winner's addr/len/dqm/we and owner, then go to ISSUE.
- ISSUE (exactly 1 cycle):
  - Drive `sdrc_rd_n`=0 (read) or `sdrc_wr_n`=0 (write), with the latched fields on `sdrc_addr`/`sdrc_data_len`/`sdrc_dqm`.
  - Pulse the owner's `pX_ack`.
  - Load the beat counter with len+1, then go to XFER.
- XFER: each owner-qualified `sdrc_rd_valid` (read) or `sdrc_wrd_ack` (write) decrements the counter. When the counter reaches 0, go to DONE.
- DONE (1 cycle): pulse the owner's `pX_done`, then go to IDLE.
- Arbitration:
  - Port 0 wins by default.
  - Port 1 wins if `p0_req`=0, or if the starvation counter equals `MAX_P0_BURSTS`.
  - The starvation counter increments on each port-0 grant while `p1_req`=1. It clears on a port-1 grant or whenever `p1_req`=0. It saturates at `MAX_P0_BURSTS`.
- Port 0 is always read; `sdrc_dqm`=0 for port-0 bursts.
- Reads: `sdrc_rd_data` is registered into the owner's `pX_rd_data`. `pX_rd_valid` is the owner-qualified `sdrc_rd_valid`, delayed 1 cycle.
- Writes: `sdrc_wr_data` = `p1_wr_data` (combinational). `p1_wr_ready` = `sdrc_wrd_ack` AND (state XFER, owner 1, write) (combinational).
- Beats that arrive outside XFER are ignored and never forwarded.
- Requests are level-sensitive. Requesters hold req/addr/len stable until `pX_ack`. A requester deasserting req before ack is legal; that request is simply not granted.

## Timing
- Reset values:
  - `sdrc_rd_n`=`sdrc_wr_n`=1; `sdrc_addr`, `sdrc_data_len`, `sdrc_dqm`=0.
  - All `pX_ack`, `pX_done`, `pX_rd_valid`, `p1_wr_ready`=0; `pX_rd_data`=0.
  - `timeout_err`=0; state INIT; starvation counter 0.
- Reset mid-burst aborts immediately to INIT; the command strobes return high on the next edge.
- Latency:
  - req sampled in IDLE → command strobe on the next cycle (ISSUE), which is the same cycle as `pX_ack`.
  - Last beat → DONE pulse 1 cycle later.
  - Minimum gap from DONE to the next ISSUE is 1 cycle, spent in IDLE.
- Simultaneous `p0_req` and `p1_req` in IDLE: resolved by the arbitration rule in the same cycle.
- `sdrc_busy_n`=0 while in IDLE: hold, no grant.
- `sdrc_init_done` dropping after INIT is ignored.
- `p0_len`=0 means 1 word; 127 means 128 words. The counter is 8 bits wide, so it holds 128 without wrap.

## Configuration
- `SDRAM_ARB_TIMEOUT_EN` defined:
  - A cycle counter runs in XFER and clears on each beat.
  - If it reaches `TIMEOUT_CYCLES`, the FSM goes to DONE: the `pX_done` pulse is still issued and `timeout_err` is set.
  - `timeout_err` clears only on reset.
- Not defined: no watchdog; XFER waits indefinitely for beats; `timeout_err` is tied to 0.

## Test plan
- Init hold: `sdrc_init_done`=0 for 50 cycles with `p0_req`=1 → no ack, strobes high. `init_done`↑ → `p0_ack` and `sdrc_rd_n`=0 together 2 cycles later.
- Port-0 read: `p0_addr`=0x00100, `p0_len`=3, 4 `sdrc_rd_valid` beats of 0xA0..0xA3 → `p0_rd_valid` 4 times, 1 cycle after each beat, with matching data; `p0_done` 1 cycle after the 4th `p0_rd_valid`.
- Port-1 write: `p1_we`=1, `p1_len`=1, `p1_dqm`=0x3 → `sdrc_wr_n`=0 for 1 cycle with `sdrc_dqm`=0x3. Two `sdrc_wrd_ack` beats → two `p1_wr_ready` beats; `sdrc_wr_data` tracks `p1_wr_data`.
- Starvation: both requests held continuously, `MAX_P0_BURSTS`=4 → grant order 0,0,0,0,1,0,0,0,0,1.
- Busy/stray beats: `sdrc_busy_n`=0 in IDLE → no grant. A `sdrc_rd_valid` pulse in IDLE → no `pX_rd_valid`.
- Timeout (macro on, `TIMEOUT_CYCLES`=16): read with `len`=3 and only 2 beats → `p0_done` about 16 cycles after the last beat, `timeout_err`=1, and the next request is granted normally.
